// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads InstructionMemory combinationally,
// buffers {pc, inst} in a 2-entry queue and hands words to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] ADDR_MASK = 32'(IMEM_DEPTH - 1);

  logic [31:0] pc;
  logic [31:0] q_pc   [2];
  logic [31:0] q_inst [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  // Handshake: decode takes the head on any cycle where out_valid and out_ready
  // are both high; out_valid never depends on out_ready, and a redirect cycle
  // suppresses out_valid so a flushed entry is never handed over.
  assign out_valid = (count != 2'd0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push      = !redirect_valid && ((count < 2'd2) || pop);

  assign imem_pc  = pc;
  assign out_inst = q_inst[head];
  assign out_pc   = q_pc[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      head         <= 1'b0;
      tail         <= 1'b0;
      count        <= 2'd0;
      misalign_err <= 1'b0;
      fetch_count  <= 32'd0;
      for (int i = 0; i < 2; i++) begin
        q_pc[i]   <= 32'd0;
        q_inst[i] <= 32'd0;
      end
    end else if (redirect_valid) begin
      // Flush wins over any push/pop; storage contents are left as stale data.
      pc    <= {redirect_pc[31:2], 2'b00} & ADDR_MASK;
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_err <= 1'b1;
      end
    end else begin
      if (push) begin
        q_pc[tail]   <= pc;
        q_inst[tail] <= imem_inst;
        tail         <= ~tail;
        pc           <= (pc + 32'd4) & ADDR_MASK;
        fetch_count  <= fetch_count + 32'd1;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected {pc, inst} handshakes are queued by
// the stimulus and consumed by a monitor on each decode handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic [63:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_DEPTH(256)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  // Clock and instruction memory model
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'h0000_0013 + ((a >> 2) << 20);
  endfunction

  assign imem_inst = imem_word(imem_pc);

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL handshake: unexpected pc=%h inst=%h, required none", out_pc, out_inst);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({out_pc, out_inst} !== e) begin
          n_bad++;
          $display("FAIL handshake: got pc=%h inst=%h, required pc=%h inst=%h",
                   out_pc, out_inst, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_pc(input logic [31:0] p);
    exp_q.push_back({p, imem_word(p)});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    check("rst_imem_pc", imem_pc, 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_misalign", 32'(misalign_err), 32'h0);
    check("rst_fetch_count", fetch_count, 32'h0);
  endtask

  task automatic do_reset();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    rst            = 1'b1;
    #1;
    check_reset();
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    tick(1);

    // Stream from reset with decode always ready
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) expect_pc(32'(i * 4));
    tick(5);
    check("stream_fetch_count", fetch_count, 32'd5);
    tick(1);
    out_ready = 1'b0;

    // Decode stall: queue fills, PC parks at 8
    do_reset();
    tick(2);
    check("stall_imem_pc_c2", imem_pc, 32'h8);
    check("stall_fetch_count", fetch_count, 32'd2);
    check("stall_out_valid", 32'(out_valid), 32'h1);
    check("stall_head_pc", out_pc, 32'h0);
    tick(1);
    check("stall_imem_pc_c3", imem_pc, 32'h8);
    tick(1);
    check("stall_imem_pc_c4", imem_pc, 32'h8);
    check("stall_fetch_count_c4", fetch_count, 32'd2);
    for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
    out_ready = 1'b1;
    tick(4);
    out_ready = 1'b0;

    // Redirect while the queue holds 0 and 4, with decode ready
    do_reset();
    tick(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    out_ready      = 1'b1;
    #1;
    check("redir_out_valid_n", 32'(out_valid), 32'h0);
    tick(1);
    redirect_valid = 1'b0;
    check("redir_imem_pc_n1", imem_pc, 32'h40);
    check("redir_out_valid_n1", 32'(out_valid), 32'h0);
    check("redir_fetch_count", fetch_count, 32'd2);
    expect_pc(32'h40);
    expect_pc(32'h44);
    tick(2);
    tick(1);
    out_ready = 1'b0;

    // Misaligned redirect, then aligned and back-to-back redirects
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick(1);
    check("misalign_imem_pc", imem_pc, 32'h40);
    check("misalign_set", 32'(misalign_err), 32'h1);
    redirect_pc = 32'h80;
    tick(1);
    check("misalign_sticky", 32'(misalign_err), 32'h1);
    check("aligned_imem_pc", imem_pc, 32'h80);
    redirect_pc = 32'h10;
    tick(1);
    redirect_pc = 32'hC0;
    tick(1);
    redirect_valid = 1'b0;
    check("b2b_imem_pc", imem_pc, 32'hC0);
    check("b2b_out_valid", 32'(out_valid), 32'h0);
    check("misalign_sticky2", 32'(misalign_err), 32'h1);
    expect_pc(32'hC0);
    expect_pc(32'hC4);
    out_ready = 1'b1;
    tick(2);
    tick(1);
    out_ready = 1'b0;

    // Wrap at the top of instruction memory
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hF8;
    out_ready      = 1'b1;
    expect_pc(32'hF8);
    expect_pc(32'hFC);
    expect_pc(32'h00);
    expect_pc(32'h04);
    tick(1);
    redirect_valid = 1'b0;
    check("wrap_imem_pc", imem_pc, 32'hF8);
    tick(4);
    tick(1);
    out_ready = 1'b0;

    // Asynchronous reset mid-cycle with a full queue
    tick(2);
    check("full_out_valid", 32'(out_valid), 32'h1);
    check("full_imem_pc", imem_pc, 32'h10);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_pc(32'h0);
    expect_pc(32'h4);
    out_ready = 1'b1;
    tick(2);
    tick(1);
    out_ready = 1'b0;
    tick(2);

    check("exp_q_drained", 32'(exp_q.size()), 32'h0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of `InstructionMemory`: owns the program counter, drives the instruction-memory address, captures the returned word into a 2-entry fetch queue and hands instructions to decode over a valid/ready handshake. Handles branch/jump redirects from execute by flushing the queue and reloading the PC. Keeps fetch running while decode stalls, until the queue fills.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- `IMEM_DEPTH`, 256, instruction memory size in bytes; power of two, at least 8.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_pc`  out  32  byte address to `InstructionMemory`; equals the internal PC register.
- `imem_inst`  in  32  instruction word returned combinationally for `imem_pc`.
- `redirect_valid`  in  1  execute requests a control-flow change this cycle.
- `redirect_pc`  in  32  redirect target byte address.
- `out_valid`  out  1  queue head holds a valid instruction for decode.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_inst`  out  32  instruction at queue head.
- `out_pc`  out  32  PC of the instruction at queue head.
- `misalign_err`  out  1  sticky flag: a redirect target had `redirect_pc[1:0] != 0`.
- `fetch_count`  out  32  number of words pushed into the queue since reset; wraps at 2^32.

## Operation
- State: PC register; 2-entry queue storing {pc, inst} with head pointer, tail pointer and `count` in 0..2; `misalign_err`; `fetch_count`.
- Pop: `pop = out_valid & out_ready`.
- Push: `push = !redirect_valid & (count < 2 | pop)`. On push, the entry is {`imem_pc`, `imem_inst`} and PC <= (PC + 4) & (IMEM_DEPTH-1). PC wraps from IMEM_DEPTH-4 to 0.
- `count` update: push and pop in the same cycle leaves `count` unchanged. A push into a full queue happens only together with a pop.
- Redirect has priority over everything:
  - Queue is emptied: count, head and tail go to 0.
  - PC <= {redirect_pc[31:2], 2'b00} & (IMEM_DEPTH-1).
  - No push and no pop are counted; `fetch_count` is unchanged.
  - If `redirect_pc[1:0] != 0`, `misalign_err` <= 1. It stays set until `rst`.
- `out_valid = (count != 0) & !redirect_valid`. Decode never sees a handshake in a redirect cycle.
- `out_inst` and `out_pc` show the head entry. When `count == 0` they hold the stale head contents (don't-care).
- `fetch_count` increments by 1 on each push.

## Timing
- Reset (async, immediate):
  - PC = RESET_PC, so `imem_pc` = RESET_PC.
  - count = 0, `out_valid` = 0.
  - Queue storage cleared, so `out_inst` = 0 and `out_pc` = 0.
  - `misalign_err` = 0, `fetch_count` = 0.
- First edge after `rst` deasserts: the word at RESET_PC is pushed. `out_valid` = 1 one cycle after reset release; PC = RESET_PC+4.
- Fetch-to-decode latency is 1 cycle; sustained throughput is 1 instruction per cycle while `out_ready` = 1.
- Decode stall (`out_ready` = 0):
  - Queue fills after 2 pushes.
  - PC then holds at the address of the next unfetched word.
  - `imem_pc` is stable while stalled.
- Redirect asserted in cycle N:
  - Cycle N+1: `imem_pc` = target, `out_valid` = 0.
  - Cycle N+2: `out_valid` = 1 with `out_pc` = target.
  - Redirect penalty is 2 cycles.
- Back-to-back redirects: the last one wins; the queue stays empty until the cycle after the final redirect.
- Reset asserted mid-operation discards all queue contents and in-flight redirects on the spot.
- `redirect_valid` together with `out_ready` = 1 and a non-empty queue: no pop; the head is discarded by the flush.

## Test plan
- Reset release with RESET_PC = 0, imem word i = 32'h0000_0013 + (i<<20), `out_ready` = 1 → out_pc sequence 0,4,8,… one per cycle from the cycle after release; `fetch_count` = 5 after 5 cycles.
- Stream with `out_ready` = 0 for 4 cycles, then 1 → count saturates at 2, `imem_pc` holds at 8, no instruction lost or duplicated; resumed out_pc order is 0,4,8,12.
- `redirect_valid` = 1 with `redirect_pc` = 32'h40 while the queue holds 0 and 4 → queue flushed; next handshakes are out_pc 0x40, 0x44; PCs 0/4 are never accepted after the redirect cycle.
- Redirect to 32'h42 → `imem_pc` = 0x40, `misalign_err` = 1; the flag stays set through later aligned redirects and clears only on `rst`.
- Sequential fetch from 0xF8 with IMEM_DEPTH = 256 → out_pc 0xF8, 0xFC, 0x00, 0x04.
- `rst` pulsed asynchronously mid-clock while the queue is full → outputs reach their reset values before the next edge; fetch restarts at RESET_PC.
